// File: rtl/ball_ctrl_pkg.sv
// Shared pong constants and the ball controller state encoding.
// Drawers and the ball controller import this package.
package ball_ctrl_pkg;

    localparam int SCREEN_W    = 800;
    localparam int SCREEN_H    = 600;
    localparam int BALL_EDGE   = 16;
    localparam int BALL_SPEED  = 4;
    localparam int PAD_L_X     = 32;
    localparam int PAD_R_X     = 752;
    localparam int PAD_W       = 16;
    localparam int PAD_H       = 64;
    localparam int SERVE_TICKS = 60;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        MOVE,
        SCORED
    } ball_state_t;

    function automatic int center(input int span, input int size);
        return (span - size) / 2;
    endfunction

endpackage

// File: rtl/ball_ctrl_frame_tick.sv
// Frame tick edge detector plus the serve hold counter.
// The counter only runs while enabled and sits at zero otherwise.
module frame_tick
    import ball_ctrl_pkg::*;
#(
    parameter int FRAMES = SERVE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic vblnk_in,
    input  logic count_en,
    output logic tick,
    output logic serve_done
);

    localparam int CW = $clog2(FRAMES + 1);

    logic          vblnk_q;
    logic [CW-1:0] cnt;

    assign tick = vblnk_in & ~vblnk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_q <= 1'b0;
            cnt     <= '0;
        end else begin
            vblnk_q <= vblnk_in;
            if (!count_en)
                cnt <= '0;
            else if (tick)
                cnt <= cnt + 1'b1;
        end
    end

    assign serve_done = count_en & tick & (cnt == CW'(FRAMES - 1));

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball controller: serve hold, per-frame motion, wall and
// paddle bounces, and miss detection with one-cycle score pulses.
module ball_ctrl
    import ball_ctrl_pkg::*;
#(
    parameter int H_ACTIVE     = SCREEN_W,
    parameter int V_ACTIVE     = SCREEN_H,
    parameter int BALL_SIZE    = BALL_EDGE,
    parameter int SPEED        = BALL_SPEED,
    parameter int PADDLE_L_X   = PAD_L_X,
    parameter int PADDLE_R_X   = PAD_R_X,
    parameter int PADDLE_W     = PAD_W,
    parameter int PADDLE_H     = PAD_H,
    parameter int SERVE_FRAMES = SERVE_TICKS
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic [11:0] paddle_l_y,
    input  logic [11:0] paddle_r_y,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        score_l,
    output logic        score_r,
    output logic        in_play
);

    localparam logic [12:0] HA  = 13'(H_ACTIVE);
    localparam logic [12:0] VA  = 13'(V_ACTIVE);
    localparam logic [12:0] BS  = 13'(BALL_SIZE);
    localparam logic [12:0] SP  = 13'(SPEED);
    localparam logic [12:0] PLX = 13'(PADDLE_L_X);
    localparam logic [12:0] PRX = 13'(PADDLE_R_X);
    localparam logic [12:0] PW  = 13'(PADDLE_W);
    localparam logic [12:0] PH  = 13'(PADDLE_H);
    localparam logic [11:0] CX  = 12'(center(H_ACTIVE, BALL_SIZE));
    localparam logic [11:0] CY  = 12'(center(V_ACTIVE, BALL_SIZE));

    ball_state_t state_q, state_d;
    logic        tick, serve_done;
    logic        dx, dy, scored_left;
    logic [12:0] x, y, pl, pr, nx, ny;
    logic        ndx, ndy;
    logic        ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r, miss;

    frame_tick #(
        .FRAMES(SERVE_FRAMES)
    ) u_tick (
        .clk       (pclk),
        .rst       (rst),
        .vblnk_in  (vblnk_in),
        .count_en  (state_q == SERVE),
        .tick      (tick),
        .serve_done(serve_done)
    );

    assign x  = {1'b0, xpos};
    assign y  = {1'b0, ypos};
    assign pl = {1'b0, paddle_l_y};
    assign pr = {1'b0, paddle_r_y};

    // Candidate next position; only committed on a non-miss tick.
    always_comb begin
        ovl_l  = (y + BS > pl) && (y < pl + PH);
        ovl_r  = (y + BS > pr) && (y < pr + PH);
        hit_l  = !dx && (x <= PLX + PW + SP) && (x >= PLX) && ovl_l;
        hit_r  = dx && (x + BS + SP >= PRX) && (x + BS <= PRX + PW) && ovl_r;
        miss_l = !dx && !hit_l && (x <= SP);
        miss_r = dx && !hit_r && (x + BS + SP >= HA);
        miss   = miss_l | miss_r;
        nx  = dx ? x + SP : x - SP;
        ndx = dx;
        if (hit_l) begin
            nx  = PLX + PW;
            ndx = 1'b1;
        end else if (hit_r) begin
            nx  = PRX - BS;
            ndx = 1'b0;
        end
        ny  = dy ? y + SP : y - SP;
        ndy = dy;
        if (!dy && y <= SP) begin
            ny  = '0;
            ndy = 1'b1;
        end else if (dy && y + BS + SP >= VA) begin
            ny  = VA - BS;
            ndy = 1'b0;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SERVE;
            SERVE:   if (serve_done) state_d = MOVE;
            MOVE:    if (tick && miss) state_d = SCORED;
            SCORED:  state_d = SERVE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_play = (state_q == MOVE);
        score_l = (state_q == SCORED) && scored_left;
        score_r = (state_q == SCORED) && !scored_left;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            xpos        <= CX;
            ypos        <= CY;
            dx          <= 1'b1;
            dy          <= 1'b1;
            scored_left <= 1'b0;
        end else begin
            unique case (state_q)
                MOVE: begin
                    if (tick && miss) begin
                        scored_left <= miss_r;
                    end else if (tick) begin
                        xpos <= nx[11:0];
                        ypos <= ny[11:0];
                        dx   <= ndx;
                        dy   <= ndy;
                    end
                end
                SCORED: begin
                    xpos <= CX;
                    ypos <= CY;
                    dx   <= scored_left;
                end
                default: begin
                    xpos <= CX;
                    ypos <= CY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl with a frame-level game model
// checked against the DUT on every negative clock edge.
module tb_ball_ctrl;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        start = 1'b0;
    logic [11:0] paddle_l_y = '0;
    logic [11:0] paddle_r_y = '0;
    logic [11:0] xpos, ypos;
    logic        score_l, score_r, in_play;

    int vectors = 0;
    int miscompares = 0;
    int cnt_sl = 0;
    int cnt_sr = 0;
    bit chk_on = 1'b0;
    bit pl_track = 1'b1;
    bit pr_track = 1'b1;

    ball_ctrl dut (
        .pclk      (pclk),
        .rst       (rst),
        .vblnk_in  (vblnk_in),
        .start     (start),
        .paddle_l_y(paddle_l_y),
        .paddle_r_y(paddle_r_y),
        .xpos      (xpos),
        .ypos      (ypos),
        .score_l   (score_l),
        .score_r   (score_r),
        .in_play   (in_play)
    );

    always #5 pclk = ~pclk;

    localparam int P_IDLE = 0, P_SERVE = 1, P_MOVE = 2, P_SCORED = 3;

    int phase = P_IDLE;
    int mx = 392, my = 292, frames = 0;
    bit mdx = 1'b1, mdy = 1'b1, mvb = 1'b0, won_l = 1'b0;

    // One game frame: move, then bounce off what was crossed.
    task automatic ball_step();
        int  pyl = int'(paddle_l_y);
        int  pyr = int'(paddle_r_y);
        bit  ov_l = (my + 16 > pyl) && (my < pyl + 64);
        bit  ov_r = (my + 16 > pyr) && (my < pyr + 64);
        bit  hit_l = !mdx && mx >= 32 && mx <= 52 && ov_l;
        bit  hit_r = mdx && mx + 20 >= 752 && mx + 16 <= 768 && ov_r;
        if (!mdx && !hit_l && mx <= 4) begin
            won_l = 1'b0;
            phase = P_SCORED;
            return;
        end
        if (mdx && !hit_r && mx + 20 >= 800) begin
            won_l = 1'b1;
            phase = P_SCORED;
            return;
        end
        my = mdy ? my + 4 : my - 4;
        if (my <= 0) begin
            my = 0;
            mdy = 1'b1;
        end else if (my + 16 >= 600) begin
            my = 584;
            mdy = 1'b0;
        end
        if (hit_l) begin
            mx = 48;
            mdx = 1'b1;
        end else if (hit_r) begin
            mx = 736;
            mdx = 1'b0;
        end else begin
            mx = mdx ? mx + 4 : mx - 4;
        end
    endtask

    initial forever begin
        bit tk;
        @(posedge pclk or posedge rst);
        if (rst) begin
            phase = P_IDLE;
            mx = 392; my = 292; mdx = 1'b1; mdy = 1'b1;
            mvb = 1'b0; frames = 0; won_l = 1'b0;
        end else begin
            tk = vblnk_in && !mvb;
            mvb = vblnk_in;
            case (phase)
                P_IDLE: if (start) begin
                    phase = P_SERVE;
                    frames = 0;
                end
                P_SERVE: if (tk) begin
                    frames++;
                    if (frames == 60) phase = P_MOVE;
                end
                P_MOVE: if (tk) ball_step();
                default: begin
                    mx = 392; my = 292; mdx = won_l;
                    phase = P_SERVE;
                    frames = 0;
                end
            endcase
        end
    end

    initial forever begin
        bit e_play, e_sl, e_sr;
        @(negedge pclk);
        if (chk_on) begin
            e_play = (phase == P_MOVE);
            e_sl = (phase == P_SCORED) && won_l;
            e_sr = (phase == P_SCORED) && !won_l;
            vectors++;
            if (xpos !== 12'(mx) || ypos !== 12'(my) || in_play !== e_play
                || score_l !== e_sl || score_r !== e_sr) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got x=%0d y=%0d play=%b sl=%b sr=%b, required x=%0d y=%0d play=%b sl=%b sr=%b",
                         $time, xpos, ypos, in_play, score_l, score_r,
                         mx, my, e_play, e_sl, e_sr);
            end
            cnt_sl += int'(score_l);
            cnt_sr += int'(score_r);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    function automatic logic [11:0] pad(input bit track, input int y);
        if (track) return 12'(y >= 24 ? y - 24 : 0);
        return 12'(y >= 150 ? 0 : 500);
    endfunction

    task automatic frame();
        @(negedge pclk);
        paddle_l_y = pad(pl_track, my);
        paddle_r_y = pad(pr_track, my);
        vblnk_in = 1'b1;
        @(negedge pclk);
        vblnk_in = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic serve_check(input string tag);
        repeat (59) frame();
        check({tag, " in_play before 60th tick"}, int'(in_play), 0);
        check({tag, " xpos held"}, int'(xpos), 392);
        check({tag, " ypos held"}, int'(ypos), 292);
        frame();
        check({tag, " in_play after 60th tick"}, int'(in_play), 1);
    endtask

    task automatic run_until_scored(input int limit, input string tag);
        int n = 0;
        while (phase == P_MOVE && n < limit) begin
            frame();
            n++;
        end
        check({tag, " rally ended within bound"}, int'(in_play), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        chk_on = 1'b1;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        check("reset xpos", int'(xpos), 392);
        check("reset ypos", int'(ypos), 292);
        check("reset in_play", int'(in_play), 0);
        check("reset score_l", int'(score_l), 0);
        check("reset score_r", int'(score_r), 0);

        start = 1'b1;
        serve_check("serve1");

        for (int t = 1; t <= 258; t++) begin
            frame();
            case (t)
                1: begin
                    check("first tick xpos", int'(xpos), 396);
                    check("first tick ypos", int'(ypos), 296);
                end
                73: begin
                    check("bottom wall ypos", int'(ypos), 584);
                    check("bottom wall xpos", int'(xpos), 684);
                end
                86: check("right paddle xpos", int'(xpos), 736);
                219: check("top wall ypos", int'(ypos), 0);
                258: begin
                    check("left paddle xpos", int'(xpos), 48);
                    check("left paddle ypos", int'(ypos), 156);
                end
                default: ;
            endcase
        end
        check("no score during rally", cnt_sl + cnt_sr, 0);

        start = 1'b0;
        pr_track = 1'b0;
        run_until_scored(300, "right miss");
        check("score_l pulses", cnt_sl, 1);
        check("score_r pulses", cnt_sr, 0);
        check("recenter xpos", int'(xpos), 392);
        check("recenter ypos", int'(ypos), 292);
        serve_check("serve2");
        frame();
        check("serve after score_l xpos", int'(xpos), 396);
        check("serve after score_l ypos", int'(ypos), 288);

        pl_track = 1'b0;
        pr_track = 1'b1;
        run_until_scored(400, "left miss");
        check("score_r pulses", cnt_sr, 1);
        serve_check("serve3");
        frame();
        check("serve after score_r xpos", int'(xpos), 388);

        start = 1'b1;
        repeat (10) frame();
        @(posedge pclk);
        #2 rst = 1'b1;
        #1;
        check("async rst xpos", int'(xpos), 392);
        check("async rst ypos", int'(ypos), 292);
        check("async rst in_play", int'(in_play), 0);
        check("async rst score", int'(score_l) + int'(score_r), 0);
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        serve_check("serve4");
        check("final score_l pulses", cnt_sl, 1);
        check("final score_r pulses", cnt_sr, 1);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ball_ctrl.md
BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 Parameters: H_ACTIVE=800 (visible width, px); V_ACTIVE=600 (visible height, px); BALL_SIZE=16 (ball square edge, px); SPEED=4 (px per frame per axis); PADDLE_L_X=32 (left paddle left edge); PADDLE_R_X=752 (right paddle left edge); PADDLE_W=16; PADDLE_H=64; SERVE_FRAMES=60 (frames held before launch).
REQ-002 Ports, one per line, as name direction width meaning:
- pclk in 1: pixel clock.
- rst in 1: reset, asynchronous, active-high.
- vblnk_in in 1: vertical blank from the timing chain.
- start in 1: level; begins play from IDLE.
- paddle_l_y in 12: left paddle top edge.
- paddle_r_y in 12: right paddle top edge.
- xpos out 12: ball left edge, feeds the ball drawer.
- ypos out 12: ball top edge, feeds the ball drawer.
- score_l out 1: one-cycle pulse, left player scored.
- score_r out 1: one-cycle pulse, right player scored.
- in_play out 1: high in MOVE.
REQ-003 One clock (pclk); reset is asynchronous and active-high (rst).

Function
REQ-004 Frame tick: vblnk_in SHALL be registered once; tick = vblnk_in & ~vblnk_q, one cycle per frame.
REQ-005 States SHALL be IDLE, SERVE, MOVE, SCORED.
REQ-006 IDLE: xpos=CX=(H_ACTIVE-BALL_SIZE)/2=392 and ypos=CY=(V_ACTIVE-BALL_SIZE)/2=292 SHALL hold; start=1 moves to SERVE on the next cycle.
REQ-007 SERVE: ball held at CX,CY; a frame counter SHALL count ticks; on the SERVE_FRAMES-th tick go to MOVE; counter cleared on SERVE entry.
REQ-008 MOVE: position SHALL update only on tick cycles; new xpos/ypos visible one pclk after tick.
REQ-009 Direction bits dx (1=right), dy (1=down); horizontal step = ±SPEED, vertical step = ±SPEED.
REQ-010 Top wall: dy=0 and ypos<=SPEED -> ypos=0, dy<=1.
REQ-011 Bottom wall: dy=1 and ypos+BALL_SIZE+SPEED>=V_ACTIVE -> ypos=V_ACTIVE-BALL_SIZE, dy<=0.
REQ-012 Vertical overlap with a paddle: ypos+BALL_SIZE>paddle_y and ypos<paddle_y+PADDLE_H.
REQ-013 Left paddle: dx=0, xpos<=PADDLE_L_X+PADDLE_W+SPEED, xpos>=PADDLE_L_X, overlap -> xpos=PADDLE_L_X+PADDLE_W, dx<=1.
REQ-014 Right paddle: dx=1, xpos+BALL_SIZE+SPEED>=PADDLE_R_X, xpos+BALL_SIZE<=PADDLE_R_X+PADDLE_W, overlap -> xpos=PADDLE_R_X-BALL_SIZE, dx<=0.
REQ-015 Miss left: dx=0, no left hit, xpos<=SPEED -> score_r pulse, state SCORED. Miss right: dx=1, no right hit, xpos+BALL_SIZE+SPEED>=H_ACTIVE -> score_l pulse, SCORED.
REQ-016 Simultaneous wall and paddle on one tick SHALL apply both clamps and both flips; miss takes priority over wall clamp.
REQ-017 SCORED: one cycle; ball to CX,CY; dx<=0 after score_r, dx<=1 after score_l; dy unchanged; go to SERVE.
REQ-018 Arithmetic SHALL use 13-bit unsigned intermediates; no wrap permitted; xpos<=H_ACTIVE-BALL_SIZE, ypos<=V_ACTIVE-BALL_SIZE always.
REQ-019 start is ignored outside IDLE; tick while SCORED is dropped.

Reset
REQ-020 rst SHALL asynchronously force: state IDLE, xpos=392, ypos=292, dx=1, dy=1, score_l=0, score_r=0, in_play=0, frame counter 0, vblnk_q=0.
REQ-021 rst mid-MOVE SHALL abort motion with no score pulse.

Structure
REQ-022 Screen, ball, paddle and speed constants plus the state encoding SHALL live in a shared pong package used by the drawers.
REQ-023 One sub-module, frame_tick (edge detector + SERVE counter), is natural; the FSM and position datapath stay in ball_ctrl.

Verification
REQ-024 Reset then start=1, 60 ticks -> in_play=1 exactly after the 60th tick; xpos=392, ypos=292 until then.
REQ-025 MOVE from (392,292) dx=1, dy=1, one tick -> (396,296) one pclk later.
REQ-026 ypos=582, dy=1, tick -> ypos=584, dy=0; ypos=3, dy=0, tick -> ypos=0, dy=1.
REQ-027 xposr=50, dx=0, paddle_l_y=280, ypos=300, tick -> xpos=48, dx=1, no score pulse.
REQ-028 xpos=2, dx=0, paddle_l_y=0, ypos=400, tick -> score_r one cycle, ball (392,292), dx=0, state SERVE.
REQ-029 rst asserted mid-MOVE asynchronously -> outputs at reset values immediately; start ignored until state IDLE.
